cache_controller: RTL and testbench

Control FSM for the direct-mapped data cache (same controller reused for the 2-way and N-way variants). It accepts one CPU request at a time and sequences the cache datapath: tag-compare result, hit service, dirty write-back to memory, and line refill (write-allocate). It sits between the CPU request interface, the cache data/tag array, and the main-memory valid/ready handshake.

---
 rtl/cache_controller.sv | 129 ++++++++++++
 tb/tb_cache_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Control FSM for the data cache: tag-compare, hit service, dirty write-back and
// write-allocate refill, with valid/ready handshakes toward main memory.
module cache_controller (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_type,
    input  logic hit,
    input  logic dirty_bit,
    input  logic ready_mem,
    output logic valid_cache,
    input  logic valid_mem,
    output logic ready_cache,
    output logic read_en_mem,
    output logic write_en_mem,
    output logic write_en,
    output logic read_en_cache,
    output logic write_en_cache,
    output logic refill,
    output logic done_cache
);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        COMPARE        = 3'd1,
        WRITE_BACK     = 3'd2,
        WRITE_ALLOCATE = 3'd3,
        REFILL_DONE    = 3'd4
    } state_e;

    state_e current_state;
    state_e next_state;
    logic   type_q;
    logic   type_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_state <= IDLE;
            type_q        <= 1'b0;
        end else begin
            current_state <= next_state;
            type_q        <= type_d;
        end
    end

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state     = current_state;
        type_d         = type_q;
        valid_cache    = 1'b0;
        ready_cache    = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        write_en       = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        refill         = 1'b0;
        done_cache     = 1'b0;

        case (current_state)
            IDLE: begin
                if (req_valid) begin
                    type_d     = req_type;
                    next_state = COMPARE;
                end
            end

            COMPARE: begin
                if (hit) begin
                    done_cache = 1'b1;
                    next_state = IDLE;
                    if (type_q) begin
                        write_en_cache = 1'b1;
                        write_en       = 1'b1;
                    end else begin
                        read_en_cache = 1'b1;
                    end
                end else if (dirty_bit) begin
                    next_state = WRITE_BACK;
                end else begin
                    next_state = WRITE_ALLOCATE;
                end
            end

            // Victim line is read out while the block is offered to memory.
            WRITE_BACK: begin
                write_en_mem  = 1'b1;
                valid_cache   = 1'b1;
                read_en_cache = 1'b1;
                if (ready_mem) begin
                    next_state = WRITE_ALLOCATE;
                end
            end

            WRITE_ALLOCATE: begin
                read_en_mem = 1'b1;
                ready_cache = 1'b1;
                if (valid_mem) begin
                    next_state = REFILL_DONE;
                end
            end

            // Write misses merge the store data into the freshly loaded line.
            REFILL_DONE: begin
                refill         = 1'b1;
                write_en_cache = 1'b1;
                write_en       = type_q;
                done_cache     = 1'b1;
                next_state     = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    a_done_single_pulse : assert property (
        @(posedge clk) disable iff (rst) done_cache |=> !done_cache
    );

    a_valid_cache_held : assert property (
        @(posedge clk) disable iff (rst) (valid_cache && !ready_mem) |=> valid_cache
    );

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: stimulus pushes per-cycle expected outputs
// into a scoreboard queue; a monitor pops and compares on the falling edge.
module tb_cache_controller;

    logic clk;
    logic rst;
    logic req_valid;
    logic req_type;
    logic hit;
    logic dirty_bit;
    logic ready_mem;
    logic valid_cache;
    logic valid_mem;
    logic ready_cache;
    logic read_en_mem;
    logic write_en_mem;
    logic write_en;
    logic read_en_cache;
    logic write_en_cache;
    logic refill;
    logic done_cache;

    cache_controller dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_type       (req_type),
        .hit            (hit),
        .dirty_bit      (dirty_bit),
        .ready_mem      (ready_mem),
        .valid_cache    (valid_cache),
        .valid_mem      (valid_mem),
        .ready_cache    (ready_cache),
        .read_en_mem    (read_en_mem),
        .write_en_mem   (write_en_mem),
        .write_en       (write_en),
        .read_en_cache  (read_en_cache),
        .write_en_cache (write_en_cache),
        .refill         (refill),
        .done_cache     (done_cache)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {valid_cache, ready_cache, read_en_mem, write_en_mem,
    //                 write_en, read_en_cache, write_en_cache, refill, done_cache}
    localparam logic [8:0] E_ZERO  = 9'b0_0000_0000;
    localparam logic [8:0] E_RDHIT = 9'b0_0000_1001;
    localparam logic [8:0] E_WRHIT = 9'b0_0001_0101;
    localparam logic [8:0] E_WB    = 9'b1_0010_1000;
    localparam logic [8:0] E_WA    = 9'b0_1100_0000;
    localparam logic [8:0] E_RF_RD = 9'b0_0000_0111;
    localparam logic [8:0] E_RF_WR = 9'b0_0001_0111;

    typedef struct {
        logic [8:0] exp;
        string      name;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       vectors;
    int       miscompares;

    wire [8:0] actual = {valid_cache, ready_cache, read_en_mem, write_en_mem,
                         write_en, read_en_cache, write_en_cache, refill, done_cache};

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t item;
            item = sb_q.pop_front();
            check(item.name, actual, item.exp);
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue the outputs
    // expected for that cycle.
    task automatic step(input bit rv, input bit rt, input bit h, input bit d,
                        input bit rm, input bit vm, input bit r,
                        input logic [8:0] e, input string nm);
        sb_item_t item;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = rv;
        req_type  = rt;
        hit       = h;
        dirty_bit = d;
        ready_mem = rm;
        valid_mem = vm;
        item.exp  = e;
        item.name = nm;
        sb_q.push_back(item);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_type  = 1'b0;
        hit       = 1'b0;
        dirty_bit = 1'b0;
        ready_mem = 1'b0;
        valid_mem = 1'b0;

        //    rv rt h  d  rm vm rst expected  name
        step(0, 0, 0, 0, 0, 0, 1, E_ZERO,  "reset_idle");
        step(0, 0, 1, 1, 1, 1, 0, E_ZERO,  "idle_no_req");

        step(1, 0, 0, 0, 0, 0, 0, E_ZERO,  "rdhit_accept");
        step(0, 1, 1, 0, 0, 0, 0, E_RDHIT, "rdhit_compare");
        step(0, 0, 0, 0, 0, 0, 0, E_ZERO,  "rdhit_idle");

        step(1, 1, 0, 0, 0, 0, 0, E_ZERO,  "wrhit_accept");
        step(0, 0, 1, 1, 0, 0, 0, E_WRHIT, "wrhit_compare");
        step(0, 0, 0, 0, 0, 0, 0, E_ZERO,  "wrhit_idle");

        step(1, 0, 0, 0, 0, 1, 0, E_ZERO,  "rdclean_accept");
        step(0, 1, 0, 0, 0, 1, 0, E_ZERO,  "rdclean_compare");
        step(1, 1, 1, 0, 0, 0, 0, E_WA,    "rdclean_wa_wait0");
        step(0, 0, 0, 0, 0, 0, 0, E_WA,    "rdclean_wa_wait1");
        step(0, 0, 0, 0, 0, 1, 0, E_WA,    "rdclean_wa_xfer");
        step(0, 0, 0, 0, 0, 0, 0, E_RF_RD, "rdclean_refill");
        step(0, 0, 0, 0, 0, 0, 0, E_ZERO,  "rdclean_idle");

        step(1, 0, 0, 0, 0, 0, 0, E_ZERO,  "rddirty_accept");
        step(0, 0, 0, 1, 0, 0, 0, E_ZERO,  "rddirty_compare");
        step(0, 0, 0, 0, 0, 1, 0, E_WB,    "rddirty_wb_hold0");
        step(0, 0, 0, 0, 0, 0, 0, E_WB,    "rddirty_wb_hold1");
        step(0, 0, 0, 0, 1, 0, 0, E_WB,    "rddirty_wb_xfer");
        step(0, 0, 0, 0, 0, 1, 0, E_WA,    "rddirty_wa_xfer");
        step(0, 0, 0, 0, 0, 0, 0, E_RF_RD, "rddirty_refill");
        step(0, 0, 0, 0, 0, 0, 0, E_ZERO,  "rddirty_idle");

        step(1, 1, 0, 0, 0, 0, 0, E_ZERO,  "wrclean_accept");
        step(0, 0, 0, 0, 0, 0, 0, E_ZERO,  "wrclean_compare");
        step(0, 0, 0, 0, 0, 1, 0, E_WA,    "wrclean_wa_xfer");
        step(0, 0, 0, 0, 0, 0, 0, E_RF_WR, "wrclean_refill");
        step(0, 0, 0, 0, 0, 0, 0, E_ZERO,  "wrclean_idle");

        step(1, 1, 0, 0, 0, 0, 0, E_ZERO,  "wrdirty_accept");
        step(0, 0, 0, 1, 0, 0, 0, E_ZERO,  "wrdirty_compare");
        step(0, 0, 0, 0, 1, 0, 0, E_WB,    "wrdirty_wb_xfer");
        step(0, 0, 0, 0, 0, 0, 0, E_WA,    "wrdirty_wa_wait");
        step(0, 0, 0, 0, 0, 1, 0, E_WA,    "wrdirty_wa_xfer");
        step(0, 0, 0, 0, 0, 0, 0, E_RF_WR, "wrdirty_refill");
        step(0, 0, 0, 0, 0, 0, 0, E_ZERO,  "wrdirty_idle");

        step(1, 1, 0, 0, 0, 0, 0, E_ZERO,  "abort_accept");
        step(0, 0, 0, 0, 0, 0, 0, E_ZERO,  "abort_compare");
        step(0, 0, 0, 0, 0, 1, 1, E_WA,    "abort_wa_rst");
        step(0, 0, 0, 0, 0, 1, 0, E_ZERO,  "abort_idle0");
        step(0, 0, 1, 0, 0, 0, 0, E_ZERO,  "abort_idle1");

        step(1, 0, 0, 0, 0, 0, 0, E_ZERO,  "post_rst_accept");
        step(0, 1, 1, 0, 0, 0, 0, E_RDHIT, "post_rst_rdhit");
        step(0, 0, 0, 0, 0, 0, 0, E_ZERO,  "post_rst_idle");

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
